// File: rtl/dma_adapter.sv
// Converts dma_control 128-byte commands into single 16-beat 64-bit AXI-HP bursts.
// Optional sticky error flag enabled by defining DMA_ADAPTER_ERR_EN.
module dma_adapter #(
   parameter int BURST_LEN = 16,
   parameter int BUSY_MIN  = 4
) (
   input  logic        hclk,
   input  logic        rst,
   input  logic        adp_val,
   input  logic [24:0] adp_addr,
   input  logic        adp_type,
   output logic        adp_busy,
   input  logic [63:0] to_data,
   input  logic        to_val,
   output logic        to_ack,
   output logic [63:0] from_data,
   output logic        from_val,
   input  logic        from_ack,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [63:0] wdata,
   output logic [7:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
`ifdef DMA_ADAPTER_ERR_EN
   ,
   output logic        adp_err,
   input  logic        adp_err_clr
`endif
);

   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int CW = $clog2(BUSY_MIN + 1);

   typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, HOLD} state_t;

   state_t          r_state;
   logic [31:0]     r_addr;
   logic [BW-1:0]   r_beat;
   logic [CW-1:0]   r_bcnt;
   logic            r_busy;
   logic            r_awvalid;
   logic            r_arvalid;
   logic            r_bready;

   logic            w_in_w;
   logic            w_in_r;
   logic            w_wvalid;
   logic            w_whs;
   logic            w_rhs;
   logic            w_last_beat;
   logic            w_min_met;
   logic            w_unused;

   assign w_in_w      = (r_state == W_ADDR) || (r_state == W_DATA);
   assign w_in_r      = (r_state == R_DATA);
   assign w_wvalid    = w_in_w && to_val && (r_beat < BW'(BURST_LEN));
   assign w_whs       = w_wvalid && wready;
   assign w_rhs       = w_in_r && rvalid && from_ack;
   assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));
   assign w_min_met   = (r_bcnt >= CW'(BUSY_MIN));
   // rlast is deliberately ignored: the beat counter decides when a read ends
   assign w_unused    = ^{rlast, rresp, bresp};

   assign adp_busy  = r_busy;
   assign awaddr    = r_addr;
   assign awvalid   = r_awvalid;
   assign awlen     = 4'(BURST_LEN - 1);
   assign awsize    = 3'd3;
   assign awburst   = 2'b01;
   assign wdata     = to_data;
   assign wstrb     = 8'hff;
   assign wvalid    = w_wvalid;
   assign wlast     = w_in_w && w_last_beat;
   assign to_ack    = w_whs;
   assign bready    = r_bready;
   assign araddr    = r_addr;
   assign arvalid   = r_arvalid;
   assign arlen     = 4'(BURST_LEN - 1);
   assign arsize    = 3'd3;
   assign arburst   = 2'b01;
   assign from_data = rdata;
   assign from_val  = w_in_r && rvalid;
   assign rready    = w_in_r && from_ack;

   always_ff @(posedge hclk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_beat    <= '0;
         r_bcnt    <= '0;
         r_busy    <= 1'b0;
         r_awvalid <= 1'b0;
         r_arvalid <= 1'b0;
         r_bready  <= 1'b0;
      end else begin
         // r_bcnt counts cycles since accept, saturating once the minimum busy time is met
         if (r_busy && !w_min_met) r_bcnt <= r_bcnt + CW'(1);
         if (w_whs || w_rhs) r_beat <= r_beat + BW'(1);
         case (r_state)
            IDLE: begin
               if (adp_val) begin
                  r_addr <= {adp_addr, 7'h0};
                  r_busy <= 1'b1;
                  r_bcnt <= CW'(1);
                  r_beat <= '0;
                  if (adp_type) begin
                     r_state   <= W_ADDR;
                     r_awvalid <= 1'b1;
                  end else begin
                     r_state   <= R_ADDR;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            W_ADDR: begin
               if (awready) begin
                  r_awvalid <= 1'b0;
                  if ((r_beat == BW'(BURST_LEN)) || (w_whs && w_last_beat)) begin
                     r_state  <= W_RESP;
                     r_bready <= 1'b1;
                  end else begin
                     r_state <= W_DATA;
                  end
               end
            end
            W_DATA: begin
               if (w_whs && w_last_beat) begin
                  r_state  <= W_RESP;
                  r_bready <= 1'b1;
               end
            end
            W_RESP: begin
               if (bvalid) begin
                  r_bready <= 1'b0;
                  r_state  <= w_min_met ? IDLE : HOLD;
                  r_busy   <= !w_min_met;
               end
            end
            R_ADDR: begin
               if (arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= R_DATA;
               end
            end
            R_DATA: begin
               if (w_rhs && w_last_beat) begin
                  r_state <= w_min_met ? IDLE : HOLD;
                  r_busy  <= !w_min_met;
               end
            end
            HOLD: begin
               if (w_min_met) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef DMA_ADAPTER_ERR_EN
   logic r_err;

   always_ff @(posedge hclk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (adp_err_clr) begin
         r_err <= 1'b0;
      end else if ((r_state == W_RESP && bvalid && bresp != 2'b00) ||
                   (w_rhs && rresp != 2'b00) || (adp_val && r_busy)) begin
         r_err <= 1'b1;
      end
   end

   assign adp_err = r_err;
`endif

endmodule

// File: tb/tb_dma_adapter.sv
// Scoreboard bench for dma_adapter: drivers queue expected AXI/FIFO traffic, negedge monitors check it.
module tb_dma_adapter;

   logic        hclk = 1'b0;
   logic        rst;
   logic        adp_val;
   logic [24:0] adp_addr;
   logic        adp_type;
   logic        adp_busy;
   logic [63:0] to_data;
   logic        to_val;
   logic        to_ack;
   logic [63:0] from_data;
   logic        from_val;
   logic        from_ack;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
`ifdef DMA_ADAPTER_ERR_EN
   logic        adp_err;
   logic        adp_err_clr;
`endif

   always #5 hclk = ~hclk;

   dma_adapter #(.BURST_LEN(16), .BUSY_MIN(20)) dut (
      .hclk(hclk), .rst(rst), .adp_val(adp_val), .adp_addr(adp_addr), .adp_type(adp_type),
      .adp_busy(adp_busy), .to_data(to_data), .to_val(to_val), .to_ack(to_ack),
      .from_data(from_data), .from_val(from_val), .from_ack(from_ack),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
`ifdef DMA_ADAPTER_ERR_EN
      , .adp_err(adp_err), .adp_err_clr(adp_err_clr)
`endif
   );

   int n_chk = 0;
   int n_pass = 0;

   logic [32:0] q_addr[$];
   logic [64:0] q_w[$];
   logic [63:0] q_r[$];
   int          q_busy[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic bad(input string name, input string msg);
      n_chk++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // Monitors: every handshake pops the next expected item
   int          busy_len = 0;
   logic [32:0] m_ea;
   logic [64:0] m_ew;
   logic [63:0] m_er;
   always @(negedge hclk) begin
      if (rst) begin
         busy_len = 0;
      end else begin
         if (awvalid && awready) begin
            if (q_addr.size() == 0) bad("aw_unexpected", $sformatf("awaddr %0h", awaddr));
            else begin
               m_ea = q_addr.pop_front();
               chk("awaddr", {1'b1, awaddr}, m_ea);
               chk("aw_const", {awlen, awsize, awburst}, {4'd15, 3'd3, 2'b01});
            end
         end
         if (arvalid && arready) begin
            if (q_addr.size() == 0) bad("ar_unexpected", $sformatf("araddr %0h", araddr));
            else begin
               m_ea = q_addr.pop_front();
               chk("araddr", {1'b0, araddr}, m_ea);
               chk("ar_const", {arlen, arsize, arburst}, {4'd15, 3'd3, 2'b01});
            end
         end
         if (wvalid && wready) begin
            if (q_w.size() == 0) bad("w_unexpected", $sformatf("wdata %0h", wdata));
            else begin
               m_ew = q_w.pop_front();
               chk("wbeat", {wlast, wdata, to_ack, wstrb}, {m_ew, 1'b1, 8'hff});
            end
         end
         if (from_val && from_ack) begin
            if (q_r.size() == 0) bad("r_unexpected", $sformatf("from_data %0h", from_data));
            else begin
               m_er = q_r.pop_front();
               chk("rbeat", {rready, from_data}, {1'b1, m_er});
            end
         end
         if (adp_busy) busy_len++;
         else if (busy_len > 0) begin
            if (q_busy.size() > 0) chk("busy_len", busy_len, q_busy.pop_front());
            busy_len = 0;
         end
      end
   end

   task automatic idle_inputs();
      adp_val = 0; adp_type = 0; to_val = 0; to_data = '0; from_ack = 0;
      awready = 0; wready = 1; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
   endtask

   task automatic chk_outputs_zero(input string name);
      chk(name, {adp_busy, awvalid, wvalid, wlast, to_ack, bready, arvalid, rready, from_val, awaddr},
          '0);
   endtask

   // Called mid-cycle; the command is accepted at the next rising edge
   task automatic do_write(input logic [24:0] addr, input logic [63:0] base, input int aw_delay,
                           input int gap_at, input int gap_len, input int b_delay,
                           input int exp_busy, input int abort_at);
      int wi = 0, gcnt = 0, bw = 0;
      logic aw_done = 0, b_done = 0, fall_seen = 0, ok = 0;
      logic aw_hs, w_hs, b_hs;
      q_addr.push_back({1'b1, addr, 7'h0});
      for (int i = 0; i < 16; i++) q_w.push_back({(i == 15), base + 64'(i)});
      if (abort_at < 0) q_busy.push_back(exp_busy);
      adp_addr = addr; adp_type = 1; adp_val = 1;
      @(posedge hclk); #1;
      adp_val = 0; adp_addr = 25'h1ffffff;
      for (int cyc = 0; cyc < 400; cyc++) begin
         awready = (cyc >= aw_delay) && !aw_done;
         if (wi == gap_at && gcnt < gap_len) begin to_val = 0; gcnt++; end
         else to_val = 1;
         to_data = base + 64'(wi);
         if (wi == 16 && !b_done) begin bvalid = (bw >= b_delay); bw++; end
         else bvalid = 0;
         @(negedge hclk);
         if (cyc == 0) chk("aw_latency", {adp_busy, awvalid}, 2'b11);
         if (b_done && !fall_seen) begin chk("busy_fall_w", adp_busy, 1'b0); fall_seen = 1; end
         if (b_done && !adp_busy) begin ok = 1; break; end
         aw_hs = awvalid && awready; w_hs = to_ack; b_hs = bvalid && bready;
         @(posedge hclk); #1;
         if (aw_hs) aw_done = 1;
         if (w_hs) wi++;
         if (b_hs) b_done = 1;
         if (abort_at >= 0 && wi == abort_at) begin
            rst = 1; #1;
            chk_outputs_zero("reset_mid_burst");
            q_w.delete(); q_addr.delete();
            idle_inputs();
            @(posedge hclk); #1 rst = 0;
            @(negedge hclk);
            return;
         end
      end
      if (!ok) bad("write_timeout", "burst did not complete");
      chk("w_queue_drained", q_w.size(), 0);
      idle_inputs();
   endtask

   task automatic do_read(input logic [24:0] addr, input logic [63:0] base, input logic toggle,
                          input int exp_busy, input int pulse_at);
      int ri = 0, nr = 0;
      logic ar_done = 0, ok = 0, ar_hs, r_hs;
      q_addr.push_back({1'b0, addr, 7'h0});
      for (int i = 0; i < 16; i++) q_r.push_back(base + 64'(i));
      q_busy.push_back(exp_busy);
      adp_addr = addr; adp_type = 0; adp_val = 1;
      @(posedge hclk); #1;
      adp_val = 0; adp_addr = 25'h1ffffff;
      for (int cyc = 0; cyc < 400; cyc++) begin
         arready = !ar_done;
         rvalid = 1; rdata = base + 64'(ri); rlast = (ri == 3);
         from_ack = toggle ? (cyc % 2 == 0) : 1'b1;
         if (cyc == pulse_at) begin adp_val = 1; adp_type = 1; adp_addr = 25'h0abcde; end
         else begin adp_val = 0; adp_type = 0; end
         @(negedge hclk);
         if (cyc == 0) chk("ar_latency", {adp_busy, arvalid}, 2'b11);
         if (cyc > 0 && !adp_busy) begin ok = 1; break; end
         ar_hs = arvalid && arready; r_hs = rvalid && rready;
         if (r_hs) nr++;
         @(posedge hclk); #1;
         if (ar_hs) ar_done = 1;
         if (r_hs) ri++;
      end
      if (!ok) bad("read_timeout", "burst did not complete");
      chk("rready_pulses", nr, 16);
      chk("r_queue_drained", q_r.size(), 0);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      adp_addr = '0;
`ifdef DMA_ADAPTER_ERR_EN
      adp_err_clr = 0;
`endif
      rst = 1;
      repeat (2) @(posedge hclk);
      #1 chk_outputs_zero("reset_state");
      rst = 0;
      @(negedge hclk);

      do_write(25'h0000010, 64'h0a00_0000_0000_0000, 0, 99, 0, 0, 0, 7);
      do_write(25'h0000001, 64'h1111_0000_0000_0000, 0, 99, 0, 5, 22, -1);
      do_read(25'h0001234, 64'h2222_0000_0000_0000, 1'b1, 33, 6);
`ifdef DMA_ADAPTER_ERR_EN
      chk("err_set", adp_err, 1'b1);
      adp_err_clr = 1;
      @(posedge hclk); #1 adp_err_clr = 0;
      chk("err_clr", adp_err, 1'b0);
      @(negedge hclk);
`endif
      do_write(25'h1555555, 64'h3333_0000_0000_0000, 10, 5, 3, 0, 20, -1);
      do_read(25'h0000abc, 64'h4444_0000_0000_0000, 1'b0, 20, -1);
      repeat (3) @(negedge hclk);
      chk("end_idle", {adp_busy, q_addr.size() == 0, q_busy.size() == 0}, 3'b011);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
